// File: rtl/img_win_ctrl.sv
// img_win_ctrl
//   Loads an IMG_W x IMG_H image from a synchronous ROM into an internal
//   buffer. It then runs commands on a 2x2 window around an operating point:
//   shift, max/min/average, rotate and mirror. The WRITE command streams the
//   whole buffer out to a RAM.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   cmd        : 4-bit command code, sampled when cmd_valid=1 and busy=0
//   cmd_valid  : command qualifier
//   IROM_Q     : ROM read data, valid the cycle after IROM_A
//   IROM_rd    : ROM read enable (high during LOAD)
//   IROM_A     : ROM address
//   IRAM_valid : RAM write strobe
//   IRAM_D     : RAM write data
//   IRAM_A     : RAM write address
//   busy       : 1 while a command cannot be accepted
//   done       : set after a complete write-out, cleared by the next command
module img_win_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  localparam int N     = IMG_W * IMG_H,
  localparam int AW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [AW-1:0]     IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [AW-1:0]     IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  // LOAD runs one cycle past the last address so that the final ROM word,
  // which arrives a cycle late, can still be stored.
  localparam logic [AW:0]     LOAD_LAST  = (AW+1)'(N);
  localparam logic [AW:0]     WRITE_LAST = (AW+1)'(N-1);
  localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1'b1);
  localparam logic [AW:0]     CNT_ZERO   = {(AW+1){1'b0}};
  localparam logic [RW-1:0]   ROW_INIT   = RW'(IMG_H/2);
  localparam logic [RW-1:0]   ROW_MAX    = RW'(IMG_H-1);
  localparam logic [RW-1:0]   ROW_ONE    = RW'(1'b1);
  localparam logic [CW-1:0]   COL_INIT   = CW'(IMG_W/2);
  localparam logic [CW-1:0]   COL_MAX    = CW'(IMG_W-1);
  localparam logic [CW-1:0]   COL_ONE    = CW'(1'b1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [AW:0]         cnt_r, cnt_nxt_s;
  logic [3:0]          cmd_r;
  logic [RW-1:0]       row_r;
  logic [CW-1:0]       col_r;
  logic [DATA_W-1:0]   pix_mem_r [N];
  logic [DATA_W-1:0]   res_r, res_calc_s;
  logic                accept_s;
  logic [AW-1:0]       ld_idx_s;
  logic [AW-1:0]       idx_tl_s, idx_tr_s, idx_bl_s, idx_br_s;
  logic [DATA_W-1:0]   pix_tl_s, pix_tr_s, pix_bl_s, pix_br_s;
  logic [DATA_W-1:0]   new_tl_s, new_tr_s, new_bl_s, new_br_s;
  logic                win_we_s;
  logic                rom_rd_nxt_s, ram_valid_nxt_s, busy_nxt_s;
  logic [AW-1:0]       rom_a_nxt_s, ram_a_nxt_s;
  logic [DATA_W-1:0]   ram_d_nxt_s;

  function automatic logic [DATA_W-1:0] max4(input logic [DATA_W-1:0] a, b, c, d);
    logic [DATA_W-1:0] m1, m2;
    m1 = (a > b) ? a : b;
    m2 = (c > d) ? c : d;
    return (m1 > m2) ? m1 : m2;
  endfunction

  function automatic logic [DATA_W-1:0] min4(input logic [DATA_W-1:0] a, b, c, d);
    logic [DATA_W-1:0] m1, m2;
    m1 = (a < b) ? a : b;
    m2 = (c < d) ? c : d;
    return (m1 < m2) ? m1 : m2;
  endfunction

  // Two guard bits make the 4-term sum exact; dropping two LSBs floors /4.
  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a, b, c, d);
    logic [DATA_W+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[DATA_W+1:2];
  endfunction

  assign accept_s = (state_r == ST_IDLE) && cmd_valid;
  assign ld_idx_s = cnt_r[AW-1:0] - AW'(1'b1);

  // Pixel index is {row, col} because both dimensions are powers of two.
  assign idx_tl_s = {row_r - ROW_ONE, col_r - COL_ONE};
  assign idx_tr_s = {row_r - ROW_ONE, col_r};
  assign idx_bl_s = {row_r, col_r - COL_ONE};
  assign idx_br_s = {row_r, col_r};
  assign pix_tl_s = pix_mem_r[idx_tl_s];
  assign pix_tr_s = pix_mem_r[idx_tr_s];
  assign pix_bl_s = pix_mem_r[idx_bl_s];
  assign pix_br_s = pix_mem_r[idx_br_s];

  // State and step counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LOAD;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_LOAD: begin
        if (cnt_r == LOAD_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_nxt_s = CNT_ZERO;
          case (cmd)
            4'd0:    state_nxt_s = ST_WRITE;
            4'd12:   state_nxt_s = ST_LOAD;
            default: state_nxt_s = ST_EXEC;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Max/min/average take a compute step and then a write-back step.
        if ((cmd_r >= 4'd5) && (cmd_r <= 4'd7) && (cnt_r == CNT_ZERO)) begin
          cnt_nxt_s = CNT_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_WRITE: begin
        if (cnt_r == WRITE_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    rom_rd_nxt_s = (state_nxt_s == ST_LOAD);
    busy_nxt_s   = (state_nxt_s != ST_IDLE);
    if (state_nxt_s == ST_LOAD) begin
      rom_a_nxt_s = cnt_nxt_s[AW-1:0];
    end else begin
      rom_a_nxt_s = {AW{1'b0}};
    end
    if (state_nxt_s == ST_WRITE) begin
      ram_valid_nxt_s = 1'b1;
      ram_a_nxt_s     = cnt_nxt_s[AW-1:0];
      ram_d_nxt_s     = pix_mem_r[cnt_nxt_s[AW-1:0]];
    end else begin
      ram_valid_nxt_s = 1'b0;
      ram_a_nxt_s     = {AW{1'b0}};
      ram_d_nxt_s     = DATA_ZERO;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IROM_rd    <= 1'b1;
      IROM_A     <= {AW{1'b0}};
      IRAM_valid <= 1'b0;
      IRAM_A     <= {AW{1'b0}};
      IRAM_D     <= DATA_ZERO;
      busy       <= 1'b1;
    end else begin
      IROM_rd    <= rom_rd_nxt_s;
      IROM_A     <= rom_a_nxt_s;
      IRAM_valid <= ram_valid_nxt_s;
      IRAM_A     <= ram_a_nxt_s;
      IRAM_D     <= ram_d_nxt_s;
      busy       <= busy_nxt_s;
    end
  end

  // Command latch, done flag and arithmetic result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_r <= 4'd0;
      done  <= 1'b0;
      res_r <= DATA_ZERO;
    end else begin
      if (accept_s) begin
        cmd_r <= cmd;
        done  <= 1'b0;
      end else if ((state_r == ST_WRITE) && (cnt_r == WRITE_LAST)) begin
        done  <= 1'b1;
      end
      if ((state_r == ST_EXEC) && (cnt_r == CNT_ZERO)) begin
        res_r <= res_calc_s;
      end
    end
  end

  // Operating point: reset/RELOAD to the centre, clamped shifts in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_r <= ROW_INIT;
      col_r <= COL_INIT;
    end else if (accept_s && (cmd == 4'd12)) begin
      row_r <= ROW_INIT;
      col_r <= COL_INIT;
    end else if (state_r == ST_EXEC) begin
      case (cmd_r)
        4'd1:    if (row_r > ROW_ONE) row_r <= row_r - ROW_ONE;
        4'd2:    if (row_r < ROW_MAX) row_r <= row_r + ROW_ONE;
        4'd3:    if (col_r > COL_ONE) col_r <= col_r - COL_ONE;
        4'd4:    if (col_r < COL_MAX) col_r <= col_r + COL_ONE;
        default: row_r <= row_r;
      endcase
    end
  end

  // Arithmetic result over the current window.
  always_comb begin
    case (cmd_r)
      4'd5:    res_calc_s = max4(pix_tl_s, pix_tr_s, pix_bl_s, pix_br_s);
      4'd6:    res_calc_s = min4(pix_tl_s, pix_tr_s, pix_bl_s, pix_br_s);
      4'd7:    res_calc_s = avg4(pix_tl_s, pix_tr_s, pix_bl_s, pix_br_s);
      default: res_calc_s = DATA_ZERO;
    endcase
  end

  // New window contents and their write enable.
  always_comb begin
    win_we_s = 1'b0;
    new_tl_s = pix_tl_s;
    new_tr_s = pix_tr_s;
    new_bl_s = pix_bl_s;
    new_br_s = pix_br_s;
    if (state_r == ST_EXEC) begin
      case (cmd_r)
        4'd5, 4'd6, 4'd7: begin
          if (cnt_r != CNT_ZERO) begin
            win_we_s = 1'b1;
            new_tl_s = res_r;
            new_tr_s = res_r;
            new_bl_s = res_r;
            new_br_s = res_r;
          end else begin
            win_we_s = 1'b0;
          end
        end
        4'd8: begin
          win_we_s = 1'b1;
          new_tl_s = pix_tr_s;
          new_tr_s = pix_br_s;
          new_br_s = pix_bl_s;
          new_bl_s = pix_tl_s;
        end
        4'd9: begin
          win_we_s = 1'b1;
          new_tl_s = pix_bl_s;
          new_tr_s = pix_tl_s;
          new_br_s = pix_tr_s;
          new_bl_s = pix_br_s;
        end
        4'd10: begin
          win_we_s = 1'b1;
          new_tl_s = pix_bl_s;
          new_bl_s = pix_tl_s;
          new_tr_s = pix_br_s;
          new_br_s = pix_tr_s;
        end
        4'd11: begin
          win_we_s = 1'b1;
          new_tl_s = pix_tr_s;
          new_tr_s = pix_tl_s;
          new_bl_s = pix_br_s;
          new_br_s = pix_bl_s;
        end
        default: win_we_s = 1'b0;
      endcase
    end else begin
      win_we_s = 1'b0;
    end
  end

  // Image buffer: filled during LOAD, window updates in EXEC; never cleared.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && (cnt_r != CNT_ZERO)) begin
      pix_mem_r[ld_idx_s] <= IROM_Q;
    end else if (win_we_s) begin
      pix_mem_r[idx_tl_s] <= new_tl_s;
      pix_mem_r[idx_tr_s] <= new_tr_s;
      pix_mem_r[idx_bl_s] <= new_bl_s;
      pix_mem_r[idx_br_s] <= new_br_s;
    end
  end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Testbench for img_win_ctrl (DATA_W=10, 8x8 image). The reference model keeps the
// image as a plain integer array and applies each command with row/col arithmetic.
module tb_img_win_ctrl;
  localparam int DW = 10;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] IROM_Q = '0;
  logic          IROM_rd;
  logic [5:0]    IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [5:0]    IRAM_A;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom [N];
  int            m_buf [N];
  int            got [N];
  int            m_row, m_col;
  logic          m_done;

  img_win_ctrl #(.DATA_W(DW), .IMG_W(8), .IMG_H(8)) u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the address.
  always @(posedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

  function automatic void model_cmd(input int c);
    int tl, tr, bl, br, a, b, cc, d, v;
    tl = (m_row - 1) * 8 + m_col - 1;
    tr = tl + 1;
    bl = m_row * 8 + m_col - 1;
    br = bl + 1;
    a = m_buf[tl]; b = m_buf[tr]; cc = m_buf[bl]; d = m_buf[br];
    case (c)
      1: if (m_row > 1) m_row = m_row - 1;
      2: if (m_row < 7) m_row = m_row + 1;
      3: if (m_col > 1) m_col = m_col - 1;
      4: if (m_col < 7) m_col = m_col + 1;
      5, 6, 7: begin
        v = a;
        if (c == 5) begin
          if (b > v) v = b;
          if (cc > v) v = cc;
          if (d > v) v = d;
        end else if (c == 6) begin
          if (b < v) v = b;
          if (cc < v) v = cc;
          if (d < v) v = d;
        end else begin
          v = (a + b + cc + d) / 4;
        end
        m_buf[tl] = v; m_buf[tr] = v; m_buf[bl] = v; m_buf[br] = v;
      end
      8:  begin m_buf[tl] = b;  m_buf[tr] = d;  m_buf[br] = cc; m_buf[bl] = a;  end
      9:  begin m_buf[tl] = cc; m_buf[tr] = a;  m_buf[br] = b;  m_buf[bl] = d;  end
      10: begin m_buf[tl] = cc; m_buf[bl] = a;  m_buf[tr] = d;  m_buf[br] = b;  end
      11: begin m_buf[tl] = b;  m_buf[tr] = a;  m_buf[bl] = d;  m_buf[br] = cc; end
      12: begin
        for (int i = 0; i < N; i++) m_buf[i] = int'(rom[i]);
        m_row = 4; m_col = 4;
      end
      default: ;
    endcase
  endfunction

  // Called right at the negedge where reset is released.
  task automatic test_load();
    int k;
    checks++;
    if (IROM_rd !== 1'b1 || IROM_A !== 6'd0) begin
      errors++; $display("FAIL load_start rd=%0b addr=%0d exp rd=1 addr=0", IROM_rd, IROM_A);
    end
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (IROM_A !== 6'(i) || IROM_rd !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL load_addr addr=%0d exp=%0d rd=%0b busy=%0b", IROM_A, i, IROM_rd, busy);
      end
    end
    k = N - 1;
    do begin @(negedge clk); k++; end while (busy === 1'b1 && k < N + 200);
    checks++;
    if (k != N + 1) begin
      errors++; $display("FAIL load_busy_fall cycle=%0d exp=%0d", k, N + 1);
    end
    checks++;
    if (done !== 1'b0 || IROM_rd !== 1'b0) begin
      errors++; $display("FAIL load_end done=%0b rd=%0b exp 0 0", done, IROM_rd);
    end
    for (int i = 0; i < N; i++) m_buf[i] = int'(rom[i]);
    m_row = 4; m_col = 4; m_done = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (IROM_rd !== 1'b1 || IROM_A !== 6'd0 || IRAM_valid !== 1'b0 || IRAM_A !== 6'd0 ||
        IRAM_D !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals rd=%0b ra=%0d v=%0b wa=%0d wd=%0d busy=%0b done=%0b exp 1 0 0 0 0 1 0",
               IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done);
    end
    reset = 1'b1;
    test_load();
  endtask

  task automatic issue_cmd(input int c, input bit pulse);
    int n, exp_busy;
    n = 0;
    while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (done !== m_done) begin
      errors++; $display("FAIL done_hold cmd=%0d got=%0b exp=%0b", c, done, m_done);
    end
    cmd = 4'(c); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL accept cmd=%0d busy=%0b done=%0b exp 1 0", c, busy, done);
    end
    if (pulse) begin cmd = 4'($urandom_range(0, 15)); cmd_valid = 1'b1; end
    n = 0;
    while (busy === 1'b1 && n < 300) begin n++; @(negedge clk); cmd_valid = 1'b0; end
    cmd_valid = 1'b0;
    exp_busy = (c >= 5 && c <= 7) ? 2 : (c == 12) ? N + 1 : 1;
    checks++;
    if (n != exp_busy) begin
      errors++; $display("FAIL busy_len cmd=%0d got=%0d exp=%0d", c, n, exp_busy);
    end
    model_cmd(c);
    m_done = 1'b0;
  endtask

  task automatic test_write();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
    cmd = 4'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (IRAM_valid !== 1'b1 || IRAM_A !== 6'(i) || IRAM_D !== DW'(m_buf[i]) ||
          busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL write_beat v=%0b a=%0d d=%0d busy=%0b done=%0b exp v=1 a=%0d d=%0d busy=1 done=0",
                 IRAM_valid, IRAM_A, IRAM_D, busy, done, i, m_buf[i]);
      end
      got[i] = int'(IRAM_D);
      @(negedge clk);
    end
    checks++;
    if (IRAM_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL write_end v=%0b done=%0b busy=%0b exp 0 1 0", IRAM_valid, done, busy);
    end
    m_done = 1'b1;
  endtask

  task automatic test_identity();
    int bad;
    test_write();
    bad = 0;
    for (int i = 0; i < N; i++) if (got[i] != i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL identity bad_pixels=%0d exp=0", bad); end
  endtask

  task automatic test_average();
    issue_cmd(12, 1'b0);
    issue_cmd(7, 1'b0);
    test_write();
    checks++;
    if (got[27] != 31 || got[28] != 31 || got[35] != 31 || got[36] != 31 || got[26] != 26) begin
      errors++; $display("FAIL avg_window got=%0d %0d %0d %0d exp=31 31 31 31", got[27], got[28], got[35], got[36]);
    end
  endtask

  task automatic test_shift_clamp();
    issue_cmd(12, 1'b0);
    repeat (5) issue_cmd(1, 1'b0);
    repeat (4) issue_cmd(3, 1'b0);
    issue_cmd(1, 1'b0);
    issue_cmd(5, 1'b0);
    test_write();
    checks++;
    if (got[0] != 9 || got[1] != 9 || got[8] != 9 || got[9] != 9 || got[2] != 2 || got[16] != 16) begin
      errors++; $display("FAIL shift_max got=%0d %0d %0d %0d exp=9 9 9 9", got[0], got[1], got[8], got[9]);
    end
  endtask

  task automatic test_rotate();
    issue_cmd(12, 1'b0);
    issue_cmd(9, 1'b0);
    test_write();
    checks++;
    if (got[27] != 35 || got[28] != 27 || got[36] != 28 || got[35] != 36) begin
      errors++; $display("FAIL rotate_cw got=%0d %0d %0d %0d exp=35 27 28 36", got[27], got[28], got[36], got[35]);
    end
    issue_cmd(8, 1'b0);
    test_write();
    checks++;
    if (got[27] != 27 || got[28] != 28 || got[36] != 36 || got[35] != 35) begin
      errors++; $display("FAIL rotate_ccw got=%0d %0d %0d %0d exp=27 28 36 35", got[27], got[28], got[36], got[35]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < N; i++) rom[i] = 10'd1023;
    rom[0] = 10'd5;
    issue_cmd(12, 1'b0);
    issue_cmd(7, 1'b1);
    issue_cmd(6, 1'b1);
    test_write();
    checks++;
    if (got[27] != 1023 || got[36] != 1023 || got[0] != 5) begin
      errors++; $display("FAIL avg_sat got=%0d %0d %0d exp=1023 1023 5", got[27], got[36], got[0]);
    end
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) rom[i] = DW'($urandom_range(0, 1023));
      issue_cmd(12, 1'b0);
      for (int j = 0; j < 40; j++) begin
        c = int'($urandom_range(1, 14));
        if (c >= 12) c++;
        issue_cmd(c, 1'($urandom_range(0, 1)));
      end
      test_write();
    end
  endtask

  task automatic test_reset_in_write();
    int n;
    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    issue_cmd(12, 1'b0);
    cmd = 4'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (IRAM_A !== 6'd20 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (IRAM_A !== 6'd20 || IRAM_valid !== 1'b1) begin
      errors++; $display("FAIL write_reach a=%0d v=%0b exp a=20 v=1", IRAM_A, IRAM_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (IRAM_valid !== 1'b0 || busy !== 1'b1 || IROM_rd !== 1'b1 || IROM_A !== 6'd0 || done !== 1'b0) begin
      errors++; $display("FAIL write_abort v=%0b busy=%0b rd=%0b ra=%0d done=%0b exp 0 1 1 0 0",
                         IRAM_valid, busy, IROM_rd, IROM_A, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_load();
    test_identity();
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    test_reset();
    test_identity();
    test_average();
    test_shift_clamp();
    test_rotate();
    test_saturate();
    test_random();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
